// File: rtl/gpu_host_arb_pkg.sv
// gpu_host_arb_pkg
// Shared types and constants for the GPU host-port (B port) arbiter and its
// read-tag pipe.
//   HOST_ADDR_W    : width of the GPU RAM host byte address bus
//   gpu_host_req_t : one host request {wr, addr, wdata}
//   rd_tag_t       : in-flight read marker {valid, req_id}

package gpu_host_arb_pkg;

    localparam int HOST_ADDR_W = 20;

    typedef struct packed {
        logic                   wr;
        logic [HOST_ADDR_W-1:0] addr;
        logic [7:0]             wdata;
    } gpu_host_req_t;

    typedef struct packed {
        logic valid;
        logic req_id;
    } rd_tag_t;

endpackage

// File: rtl/gpu_rd_tag_pipe.sv
// gpu_rd_tag_pipe
// Shift register of read tags, DEPTH stages long. The tag leaving the last
// stage steers the RAM read byte into the matching requester's output
// register and raises that requester's one-cycle valid strobe.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   tag_in                  : tag entering the pipe this cycle
//   rdata                   : read byte from the RAM
//   rd_valid_0 / rd_valid_1 : one-cycle return strobes
//   rd_data_0  / rd_data_1  : returned bytes, held between returns

module gpu_rd_tag_pipe
    import gpu_host_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  rd_tag_t    tag_in,
    input  logic [7:0] rdata,
    output logic       rd_valid_0,
    output logic       rd_valid_1,
    output logic [7:0] rd_data_0,
    output logic [7:0] rd_data_1
);

    rd_tag_t stage [DEPTH];
    rd_tag_t tag_out;

    // Advance every tag one stage per clock; reset empties the pipe so
    // reads in flight at reset never produce a return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

    // Capture the RAM byte for whichever requester owns the departing tag;
    // the other requester's data register keeps its previous value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_0 <= 1'b0;
            rd_valid_1 <= 1'b0;
            rd_data_0  <= 8'h00;
            rd_data_1  <= 8'h00;
        end else begin
            rd_valid_0 <= tag_out.valid && !tag_out.req_id;
            rd_valid_1 <= tag_out.valid &&  tag_out.req_id;
            if (tag_out.valid && !tag_out.req_id) begin
                rd_data_0 <= rdata;
            end
            if (tag_out.valid && tag_out.req_id) begin
                rd_data_1 <= rdata;
            end
        end
    end

endmodule

// File: rtl/gpu_host_port_arbiter.sv
// gpu_host_port_arbiter
// Two-requester arbiter for the host byte port (B port) of the GPU
// dual-port RAM. Requester 0 is the Z80 bus interface, requester 1 the
// geometry/blitter engine. One access is issued per clock and each read
// byte is routed back to the requester that issued it.
// Configuration macro:
//   GPU_HOST_ARB_FIXED_PRIO_EN defined   : requester 0 always wins ties
//   GPU_HOST_ARB_FIXED_PRIO_EN undefined : round-robin on ties (default)
// Ports:
//   clk, rst                      : clock (also RAM clk_b), async active-high reset
//   req_valid_N / req_ready_N     : request handshake, ready is the grant
//   req_wr_N, req_addr_N, req_wdata_N : request fields (1 = write)
//   rd_valid_N / rd_data_N        : read return strobe and byte
//   ram_wr_ena, ram_addr, ram_wdata, ram_rdata : RAM B port

module gpu_host_port_arbiter
    import gpu_host_arb_pkg::*;
#(
    parameter int ADDR_W     = HOST_ADDR_W,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic              req_wr_0,
    input  logic              req_wr_1,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [7:0]        req_wdata_0,
    input  logic [7:0]        req_wdata_1,
    output logic              rd_valid_0,
    output logic              rd_valid_1,
    output logic [7:0]        rd_data_0,
    output logic [7:0]        rd_data_1,
    output logic              ram_wr_ena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    logic              grant_any;
    logic              win_wr;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0]        win_wdata;
    rd_tag_t           issue_tag;

`ifdef GPU_HOST_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is valid. Grants are
    // suppressed while reset is asserted.
    always_comb begin
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        if (!rst) begin
            if (req_valid_0) begin
                req_ready_0 = 1'b1;
            end else if (req_valid_1) begin
                req_ready_1 = 1'b1;
            end
        end
    end
`else
    logic last;

    // Round-robin grant: on a tie the requester that was not granted last
    // wins. Grants are suppressed while reset is asserted.
    always_comb begin
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        if (!rst) begin
            if (req_valid_0 && req_valid_1) begin
                req_ready_0 = last;
                req_ready_1 = !last;
            end else if (req_valid_0) begin
                req_ready_0 = 1'b1;
            end else if (req_valid_1) begin
                req_ready_1 = 1'b1;
            end
        end
    end

    // Remember the last winner; it starts at 1 so requester 0 goes first,
    // and it only moves on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (req_ready_0) begin
            last <= 1'b0;
        end else if (req_ready_1) begin
            last <= 1'b1;
        end
    end
`endif

    assign grant_any = req_ready_0 || req_ready_1;

    // Select the winning request's fields for the RAM registers.
    always_comb begin
        win_wr    = req_wr_0;
        win_addr  = req_addr_0;
        win_wdata = req_wdata_0;
        if (req_ready_1) begin
            win_wr    = req_wr_1;
            win_addr  = req_addr_1;
            win_wdata = req_wdata_1;
        end
    end

    // Register the accepted access onto the RAM port. The read tag is
    // registered alongside the address so it enters the tag pipe in step
    // with the RAM seeing the address; the pipe then covers the RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wr_ena <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 8'h00;
            issue_tag  <= '0;
        end else begin
            ram_wr_ena <= 1'b0;
            issue_tag  <= '0;
            if (grant_any) begin
                ram_wr_ena       <= win_wr;
                ram_addr         <= win_addr;
                ram_wdata        <= win_wdata;
                issue_tag.valid  <= !win_wr;
                issue_tag.req_id <= req_ready_1;
            end
        end
    end

    gpu_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .tag_in     (issue_tag),
        .rdata      (ram_rdata),
        .rd_valid_0 (rd_valid_0),
        .rd_valid_1 (rd_valid_1),
        .rd_data_0  (rd_data_0),
        .rd_data_1  (rd_data_1)
    );

endmodule

// File: tb/tb_gpu_host_port_arbiter.sv
// tb_gpu_host_port_arbiter
// Self-checking bench for gpu_host_port_arbiter with RD_LATENCY = 2. A small
// behavioural RAM model sits on the B port. A table of per-cycle vectors
// drives arbitration, writes and reads; hand sequences cover reset in
// flight and, when GPU_HOST_ARB_FIXED_PRIO_EN is defined, fixed priority.

module tb_gpu_host_port_arbiter;

    localparam int ADDR_W = 20;
    localparam int NV     = 22;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic              req_ready_0, req_ready_1;
    logic              req_wr_0 = 1'b0, req_wr_1 = 1'b0;
    logic [ADDR_W-1:0] req_addr_0 = '0, req_addr_1 = '0;
    logic [7:0]        req_wdata_0 = '0, req_wdata_1 = '0;
    logic              rd_valid_0, rd_valid_1;
    logic [7:0]        rd_data_0, rd_data_1;
    logic              ram_wr_ena;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata = 8'h00;

    int errors = 0;
    int checks = 0;

    gpu_host_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .RD_LATENCY (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .req_wr_0    (req_wr_0),
        .req_wr_1    (req_wr_1),
        .req_addr_0  (req_addr_0),
        .req_addr_1  (req_addr_1),
        .req_wdata_0 (req_wdata_0),
        .req_wdata_1 (req_wdata_1),
        .rd_valid_0  (rd_valid_0),
        .rd_valid_1  (rd_valid_1),
        .rd_data_0   (rd_data_0),
        .rd_data_1   (rd_data_1),
        .ram_wr_ena  (ram_wr_ena),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: two-clock read latency. Unwritten bytes read as addr+0x40,
    // except 0x34 which holds 0x5A.
    logic [7:0]   mem [256];
    logic [255:0] wmask = '0;
    logic [7:0]   ram_addr_q = 8'h00;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h34) ? 8'h5A : a + 8'h40;
    endfunction

    always @(posedge clk) begin
        if (ram_wr_ena) begin
            mem[ram_addr[7:0]]   <= ram_wdata;
            wmask[ram_addr[7:0]] <= 1'b1;
        end
        ram_addr_q <= ram_addr[7:0];
        ram_rdata  <= wmask[ram_addr_q] ? mem[ram_addr_q] : init_val(ram_addr_q);
    end

    typedef struct {
        logic        v0, v1, wr0, wr1;
        logic [19:0] a0, a1;
        logic [7:0]  d0, d1;
        logic        er0, er1, ewr;
        logic [19:0] eaddr;
        logic [7:0]  ewd;
        logic        erv0, erv1;
        logic [7:0]  erd0, erd1;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mkv(
        input logic v0, v1, wr0, wr1, input logic [19:0] a0, a1, input logic [7:0] d0, d1,
        input logic er0, er1, ewr, input logic [19:0] eaddr, input logic [7:0] ewd,
        input logic erv0, erv1, input logic [7:0] erd0, erd1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.wr0 = wr0; v.wr1 = wr1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.er0 = er0; v.er1 = er1; v.ewr = ewr; v.eaddr = eaddr; v.ewd = ewd;
        v.erv0 = erv0; v.erv1 = erv1; v.erd0 = erd0; v.erd1 = erd1;
        return v;
    endfunction

    task automatic applyStimulus(input logic v0, v1, wr0, wr1, input logic [19:0] a0, a1,
                                 input logic [7:0] d0, d1);
        req_valid_0 = v0;  req_valid_1 = v1;
        req_wr_0    = wr0; req_wr_1    = wr1;
        req_addr_0  = a0;  req_addr_1  = a1;
        req_wdata_0 = d0;  req_wdata_1 = d1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 20'h0, 20'h0, 8'h00, 8'h00);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //      v0 v1 w0 w1  a0        a1        d0     d1     r0 r1 wr addr      wdata  rv0 rv1 rd0    rd1
        tbl[0]  = mkv(1, 1, 0, 0, 20'h00011, 20'h00021, 8'h00, 8'h00, 1, 0, 0, 20'h00011, 8'h00, 0, 0, 8'h00, 8'h00);
        tbl[1]  = mkv(1, 1, 0, 0, 20'h00012, 20'h00021, 8'h00, 8'h00, 0, 1, 0, 20'h00021, 8'h00, 0, 0, 8'h00, 8'h00);
        tbl[2]  = mkv(1, 1, 0, 0, 20'h00012, 20'h00022, 8'h00, 8'h00, 1, 0, 0, 20'h00012, 8'h00, 0, 0, 8'h00, 8'h00);
        tbl[3]  = mkv(1, 1, 0, 0, 20'h00013, 20'h00022, 8'h00, 8'h00, 0, 1, 0, 20'h00022, 8'h00, 1, 0, 8'h51, 8'h00);
        tbl[4]  = mkv(1, 1, 0, 0, 20'h00013, 20'h00023, 8'h00, 8'h00, 1, 0, 0, 20'h00013, 8'h00, 0, 1, 8'h51, 8'h61);
        tbl[5]  = mkv(1, 1, 0, 0, 20'h00014, 20'h00023, 8'h00, 8'h00, 0, 1, 0, 20'h00023, 8'h00, 1, 0, 8'h52, 8'h61);
        tbl[6]  = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00023, 8'h00, 0, 1, 8'h52, 8'h62);
        tbl[7]  = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00023, 8'h00, 1, 0, 8'h53, 8'h62);
        tbl[8]  = mkv(0, 1, 0, 1, 20'h00000, 20'h00010, 8'h00, 8'hA5, 0, 1, 1, 20'h00010, 8'hA5, 0, 1, 8'h53, 8'h63);
        tbl[9]  = mkv(0, 1, 0, 0, 20'h00000, 20'h00010, 8'h00, 8'h00, 0, 1, 0, 20'h00010, 8'h00, 0, 0, 8'h53, 8'h63);
        tbl[10] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00010, 8'h00, 0, 0, 8'h53, 8'h63);
        tbl[11] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00010, 8'h00, 0, 0, 8'h53, 8'h63);
        tbl[12] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00010, 8'h00, 0, 1, 8'h53, 8'hA5);
        tbl[13] = mkv(1, 0, 0, 0, 20'h01234, 20'h00000, 8'h00, 8'h00, 1, 0, 0, 20'h01234, 8'h00, 0, 0, 8'h53, 8'hA5);
        tbl[14] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h01234, 8'h00, 0, 0, 8'h53, 8'hA5);
        tbl[15] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h01234, 8'h00, 0, 0, 8'h53, 8'hA5);
        tbl[16] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h01234, 8'h00, 1, 0, 8'h5A, 8'hA5);
        tbl[17] = mkv(1, 1, 0, 0, 20'h00014, 20'h00024, 8'h00, 8'h00, 0, 1, 0, 20'h00024, 8'h00, 0, 0, 8'h5A, 8'hA5);
        tbl[18] = mkv(1, 0, 0, 0, 20'h00014, 20'h00000, 8'h00, 8'h00, 1, 0, 0, 20'h00014, 8'h00, 0, 0, 8'h5A, 8'hA5);
        tbl[19] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00014, 8'h00, 0, 0, 8'h5A, 8'hA5);
        tbl[20] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00014, 8'h00, 0, 1, 8'h5A, 8'h64);
        tbl[21] = mkv(0, 0, 0, 0, 20'h00000, 20'h00000, 8'h00, 8'h00, 0, 0, 0, 20'h00014, 8'h00, 1, 0, 8'h54, 8'h64);

        // Reset with both requesters valid: no grant, all outputs zero.
        applyStimulus(1, 1, 0, 0, 20'h00011, 20'h00021, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("reset ready0", 32'(req_ready_0), 32'h0);
        checkOutput("reset ready1", 32'(req_ready_1), 32'h0);
        checkOutput("reset ram_wr_ena", 32'(ram_wr_ena), 32'h0);
        checkOutput("reset ram_addr", 32'(ram_addr), 32'h0);
        checkOutput("reset ram_wdata", 32'(ram_wdata), 32'h0);
        checkOutput("reset rd_valid", {30'h0, rd_valid_1, rd_valid_0}, 32'h0);
        checkOutput("reset rd_data", {16'h0, rd_data_1, rd_data_0}, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef GPU_HOST_ARB_FIXED_PRIO_EN
        // Both valid for 4 cycles: requester 0 wins every time.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 0, 0, 20'h00030 + 20'(i), 20'h00040, 8'h00, 8'h00);
            @(negedge clk);
            checkOutput($sformatf("fixed%0d ready0", i), 32'(req_ready_0), 32'h1);
            checkOutput($sformatf("fixed%0d ready1", i), 32'(req_ready_1), 32'h0);
            @(posedge clk); #1;
            checkOutput($sformatf("fixed%0d ram_addr", i), 32'(ram_addr), 32'h30 + 32'(i));
        end
        for (int i = 0; i < 4; i++) idleCycle();
`else
        for (int k = 0; k < NV; k++) begin
            applyStimulus(tbl[k].v0, tbl[k].v1, tbl[k].wr0, tbl[k].wr1,
                          tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1);
            @(negedge clk);
            checkOutput($sformatf("v%0d ready0", k), 32'(req_ready_0), 32'(tbl[k].er0));
            checkOutput($sformatf("v%0d ready1", k), 32'(req_ready_1), 32'(tbl[k].er1));
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d ram_wr_ena", k), 32'(ram_wr_ena), 32'(tbl[k].ewr));
            checkOutput($sformatf("v%0d ram_addr", k), 32'(ram_addr), 32'(tbl[k].eaddr));
            checkOutput($sformatf("v%0d ram_wdata", k), 32'(ram_wdata), 32'(tbl[k].ewd));
            checkOutput($sformatf("v%0d rd_valid_0", k), 32'(rd_valid_0), 32'(tbl[k].erv0));
            checkOutput($sformatf("v%0d rd_valid_1", k), 32'(rd_valid_1), 32'(tbl[k].erv1));
            checkOutput($sformatf("v%0d rd_data_0", k), 32'(rd_data_0), 32'(tbl[k].erd0));
            checkOutput($sformatf("v%0d rd_data_1", k), 32'(rd_data_1), 32'(tbl[k].erd1));
        end
`endif

        // Two reads in flight, then reset: neither may return.
        applyStimulus(1, 0, 0, 0, 20'h00015, 20'h00000, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("midrst ready0 a", 32'(req_ready_0), 32'h1);
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 0, 20'h00016, 20'h00000, 8'h00, 8'h00);
        @(posedge clk); #1;
        checkOutput("midrst ram_addr", 32'(ram_addr), 32'h16);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 20'h0, 20'h0, 8'h00, 8'h00);
        #1;
        checkOutput("midrst ram_addr cleared", 32'(ram_addr), 32'h0);
        checkOutput("midrst rd_data_0 cleared", 32'(rd_data_0), 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("midrst drop%0d rd_valid", i), {30'h0, rd_valid_1, rd_valid_0}, 32'h0);
        end

        // New read after reset returns 0x5A to requester 0 after 3 edges.
        applyStimulus(1, 0, 0, 0, 20'h01234, 20'h00000, 8'h00, 8'h00);
        @(negedge clk);
        checkOutput("post ready0", 32'(req_ready_0), 32'h1);
        @(posedge clk); #1;
        checkOutput("post ram_addr", 32'(ram_addr), 32'h01234);
        checkOutput("post ram_wr_ena", 32'(ram_wr_ena), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) idleCycle();
            else begin
                applyStimulus(0, 0, 0, 0, 20'h0, 20'h0, 8'h00, 8'h00);
                @(posedge clk); #1;
            end
            checkOutput($sformatf("post e%0d rd_valid_0", i), 32'(rd_valid_0), (i == 3) ? 32'h1 : 32'h0);
            checkOutput($sformatf("post e%0d rd_valid_1", i), 32'(rd_valid_1), 32'h0);
        end
        checkOutput("post rd_data_0", 32'(rd_data_0), 32'h5A);
        checkOutput("post rd_data_1", 32'(rd_data_1), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
